// File: rtl/approx_eval_pkg.sv
// Shared types, default widths and saturating arithmetic for approximate-adder
// characterisation blocks.
package approx_eval_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 32;
  localparam int DEF_ACC_W = 48;
  localparam int SAT_W     = 64;

  // w-bit unsigned add carried in SAT_W bits (w <= SAT_W); MSB of the result flags clipping.
  function automatic logic [SAT_W:0] sat_add(input logic [SAT_W-1:0] acc,
                                             input logic [SAT_W-1:0] inc,
                                             input int unsigned      w);
    logic [SAT_W:0] sum;
    logic [SAT_W:0] lim;
    lim = (w >= SAT_W) ? {1'b0, {SAT_W{1'b1}}} : (((SAT_W+1)'(1)) << w) - (SAT_W+1)'(1);
    sum = {1'b0, acc} + {1'b0, inc};
    if (sum > lim) sat_add = {1'b1, lim[SAT_W-1:0]};
    else           sat_add = {1'b0, sum[SAT_W-1:0]};
  endfunction

endpackage

// File: rtl/approx_err_calc.sv
// Combinational exact sum and absolute error of an approximate WIDTH-bit adder result.
module approx_err_calc #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   approx_sum,
  output logic [WIDTH:0]   abs_err
);

  logic        [WIDTH:0]   w_exact;
  logic signed [WIDTH+1:0] w_diff;
  logic signed [WIDTH+1:0] w_neg;

  assign w_exact = {1'b0, a} + {1'b0, b};
  assign w_diff  = $signed({1'b0, approx_sum}) - $signed({1'b0, w_exact});
  assign w_neg   = -w_diff;
  // Magnitude never exceeds 2^(WIDTH+1)-1, so dropping the sign bit is lossless.
  assign abs_err = w_diff[WIDTH+1] ? w_neg[WIDTH:0] : w_diff[WIDTH:0];

endmodule

// File: rtl/approx_err_monitor.sv
// Windowed error statistics (count, distance sum, worst case) for an approximate adder.
// Two-stage pipeline: stage 1 registers the error, stage 2 is the statistics update.
module approx_err_monitor
  import approx_eval_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH:0]   in_sum,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] err_sum,
  output logic [WIDTH:0]   err_max,
  output logic [WIDTH-1:0] max_a,
  output logic [WIDTH-1:0] max_b,
  output logic             acc_sat
);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_len, r_acc_cnt, w_acc_cnt_nxt;
  logic             r_s1_vld;
  logic [WIDTH:0]   r_s1_err;
  logic [WIDTH-1:0] r_s1_a, r_s1_b;
  logic [CNT_W-1:0] r_sample_cnt, r_err_cnt;
  logic [ACC_W-1:0] r_err_sum;
  logic [WIDTH:0]   r_err_max;
  logic [WIDTH-1:0] r_max_a, r_max_b;
  logic             r_acc_sat;
  logic [WIDTH:0]   w_abs_err;
  logic [SAT_W:0]   w_sat;
  logic             w_accept, w_last, w_start_ok;

  approx_err_calc #(.WIDTH(WIDTH)) u_calc (
    .a          (in_a),
    .b          (in_b),
    .approx_sum (in_sum),
    .abs_err    (w_abs_err)
  );

  // Accept is decoded from state rather than in_ready to keep the FSM free of comb loops.
  assign w_accept      = in_valid & (r_state == RUN);
  assign w_start_ok    = start & ((r_state == IDLE) | (r_state == DONE));
  assign w_acc_cnt_nxt = r_acc_cnt + CNT_W'(1);
  assign w_last        = w_accept & (w_acc_cnt_nxt == r_len);
  assign w_sat         = sat_add(SAT_W'(r_err_sum), SAT_W'(r_s1_err), ACC_W);

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        done = (r_state == DONE);
        if (start) w_state_nxt = (n_samples == '0) ? DONE : RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_last) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        // Stage 2 is the statistics registers, so an empty stage 1 means fully retired.
        if (!r_s1_vld) w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_len        <= '0;
      r_acc_cnt    <= '0;
      r_s1_vld     <= 1'b0;
      r_s1_err     <= '0;
      r_s1_a       <= '0;
      r_s1_b       <= '0;
      r_sample_cnt <= '0;
      r_err_cnt    <= '0;
      r_err_sum    <= '0;
      r_err_max    <= '0;
      r_max_a      <= '0;
      r_max_b      <= '0;
      r_acc_sat    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_err  <= w_abs_err;
        r_s1_a    <= in_a;
        r_s1_b    <= in_b;
        r_acc_cnt <= w_acc_cnt_nxt;
      end
      if (w_start_ok) begin
        r_len        <= n_samples;
        r_acc_cnt    <= '0;
        r_sample_cnt <= '0;
        r_err_cnt    <= '0;
        r_err_sum    <= '0;
        r_err_max    <= '0;
        r_max_a      <= '0;
        r_max_b      <= '0;
        r_acc_sat    <= 1'b0;
      end else if (r_s1_vld) begin
        r_sample_cnt <= r_sample_cnt + CNT_W'(1);
        r_err_cnt    <= r_err_cnt + CNT_W'(r_s1_err != '0);
        r_err_sum    <= w_sat[ACC_W-1:0];
        r_acc_sat    <= r_acc_sat | w_sat[SAT_W];
        if (r_s1_err > r_err_max) begin
          r_err_max <= r_s1_err;
          r_max_a   <= r_s1_a;
          r_max_b   <= r_s1_b;
        end
      end
    end
  end

  assign sample_cnt = r_sample_cnt;
  assign err_cnt    = r_err_cnt;
  assign err_sum    = r_err_sum;
  assign err_max    = r_err_max;
  assign max_a      = r_max_a;
  assign max_b      = r_max_b;
  assign acc_sat    = r_acc_sat;

endmodule

// File: tb/tb_approx_err_monitor.sv
// Randomised self-checking bench: two monitors (48-bit and 8-bit accumulators) share
// one stimulus stream and are compared against a plain-arithmetic reference model.
module tb_approx_err_monitor;
  localparam int W  = 16;
  localparam int CW = 32;
  localparam int AW = 48;
  localparam int VW = 2*CW + AW + (W+1) + 2*W + 1;
  typedef logic [VW-1:0] sv_t;
  typedef struct packed { logic [W-1:0] a; logic [W-1:0] b; logic [W:0] s; } beat_t;

  logic clk = 0, rst_n = 0, start = 0, in_valid = 0;
  logic [CW-1:0] n_samples = '0;
  logic [W-1:0]  in_a = '0, in_b = '0;
  logic [W:0]    in_sum = '0;

  logic in_ready, busy, done, acc_sat;
  logic [CW-1:0] sample_cnt, err_cnt;
  logic [AW-1:0] err_sum;
  logic [W:0]    err_max;
  logic [W-1:0]  max_a, max_b;

  logic d8_in_ready, d8_busy, d8_done, d8_acc_sat;
  logic [CW-1:0] d8_sample_cnt, d8_err_cnt;
  logic [7:0]    d8_err_sum;
  logic [W:0]    d8_err_max;
  logic [W-1:0]  d8_max_a, d8_max_b;

  int errors = 0, checks = 0;
  beat_t bq[$];
  sv_t obs, obs8;

  approx_err_monitor #(.WIDTH(W), .CNT_W(CW), .ACC_W(AW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_sum(in_sum),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .err_sum(err_sum), .err_max(err_max), .max_a(max_a), .max_b(max_b), .acc_sat(acc_sat));

  approx_err_monitor #(.WIDTH(W), .CNT_W(CW), .ACC_W(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(d8_in_ready), .in_a(in_a), .in_b(in_b), .in_sum(in_sum),
    .busy(d8_busy), .done(d8_done), .sample_cnt(d8_sample_cnt), .err_cnt(d8_err_cnt),
    .err_sum(d8_err_sum), .err_max(d8_err_max), .max_a(d8_max_a), .max_b(d8_max_b),
    .acc_sat(d8_acc_sat));

  assign obs  = {sample_cnt, err_cnt, err_sum, err_max, max_a, max_b, acc_sat};
  assign obs8 = {d8_sample_cnt, d8_err_cnt, AW'(d8_err_sum), d8_err_max, d8_max_a, d8_max_b, d8_acc_sat};

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  // Reference statistics over the first nb queued beats for an aw-bit accumulator.
  function automatic sv_t model(input int aw, input int nb);
    longint e, sum = 0, mx = 0, lim;
    int ec = 0;
    logic sat = 0;
    logic [W-1:0] ma = '0, mb = '0;
    lim = (longint'(1) << aw) - 1;
    for (int i = 0; i < nb; i++) begin
      e = longint'(bq[i].s) - (longint'(bq[i].a) + longint'(bq[i].b));
      if (e < 0) e = -e;
      if (e != 0) ec++;
      if (sum + e > lim) begin sum = lim; sat = 1; end
      else sum = sum + e;
      if (e > mx) begin mx = e; ma = bq[i].a; mb = bq[i].b; end
    end
    return {CW'(nb), CW'(ec), AW'(sum), (W+1)'(mx), ma, mb, sat};
  endfunction

  function automatic beat_t rnd_beat();
    beat_t bt;
    int ex, sv;
    bt.a = W'($urandom);
    bt.b = W'($urandom);
    ex = int'(bt.a) + int'(bt.b);
    case ($urandom_range(0, 2))
      0: sv = ex;
      1: sv = ex + int'($urandom_range(0, 8)) - 4;
      default: sv = int'($urandom_range(0, (1 << (W+1)) - 1));
    endcase
    bt.s = sv[W:0];
    return bt;
  endfunction

  task automatic do_start(input int n);
    start = 1; n_samples = CW'(n);
    @(negedge clk);
    start = 0;
  endtask

  // Presents every queued beat; bad counts cycles where the window unexpectedly stalled.
  task automatic feed(input bit gaps, output int bad);
    int guard;
    bad = 0;
    foreach (bq[i]) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin in_valid = 0; @(negedge clk); end
      in_valid = 1; in_a = bq[i].a; in_b = bq[i].b; in_sum = bq[i].s;
      guard = 0;
      while (!in_ready && guard < 20) begin bad++; guard++; @(negedge clk); end
      @(negedge clk);
    end
    in_valid = 0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 50) begin @(negedge clk); cyc++; end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    checks++; if ({in_ready, busy, done} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {in_ready, busy, done}); end
    checks++; if (obs !== '0) begin errors++; $display("FAIL reset_stats: got %h want 0", obs); end
    checks++; if (obs8 !== '0) begin errors++; $display("FAIL reset_stats8: got %h want 0", obs8); end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int bad;
    bq.delete(); bq.push_back('{a:16'h0001, b:16'h0001, s:17'h00002});
    do_start(1);
    checks++; if ({in_ready, busy} !== 2'b11) begin errors++; $display("FAIL single_run: got %b want 11", {in_ready, busy}); end
    feed(0, bad);
    @(negedge clk);
    checks++; if (done !== 1'b0 || sample_cnt !== 1) begin errors++; $display("FAIL single_lat2: done=%b cnt=%0d want 0/1", done, sample_cnt); end
    @(negedge clk);
    checks++; if ({done, busy} !== 2'b10) begin errors++; $display("FAIL single_done: got %b want 10", {done, busy}); end
    checks++; if (obs !== model(AW, 1) || bad != 0) begin errors++; $display("FAIL single_stats: got %h want %h bad=%0d", obs, model(AW, 1), bad); end
  endtask

  task automatic test_error_max();
    int bad, cyc;
    bq.delete();
    bq.push_back('{a:16'h07FF, b:16'h0001, s:17'h00000});
    bq.push_back('{a:16'hFFFF, b:16'hFFFF, s:17'h1FFFE});
    do_start(2);
    feed(1, bad);
    wait_done(cyc);
    checks++; if (cyc != 2 || bad != 0) begin errors++; $display("FAIL errmax_lat: cyc=%0d bad=%0d want 2/0", cyc, bad); end
    checks++; if (err_cnt !== 1 || err_sum !== 48'h800 || err_max !== 17'h800 || max_a !== 16'h07FF || max_b !== 16'h0001)
      begin errors++; $display("FAIL errmax_vals: cnt=%0d sum=%h max=%h a=%h b=%h", err_cnt, err_sum, err_max, max_a, max_b); end
    checks++; if (obs !== model(AW, 2)) begin errors++; $display("FAIL errmax_model: got %h want %h", obs, model(AW, 2)); end
  endtask

  task automatic test_tie();
    int bad, cyc;
    bq.delete();
    bq.push_back('{a:16'd10,  b:16'd20,  s:17'd35});
    bq.push_back('{a:16'd100, b:16'd200, s:17'd295});
    do_start(2);
    feed(1, bad);
    wait_done(cyc);
    checks++; if (err_max !== 17'd5 || max_a !== 16'd10 || max_b !== 16'd20)
      begin errors++; $display("FAIL tie: max=%0d a=%0d b=%0d want 5/10/20", err_max, max_a, max_b); end
    checks++; if (obs !== model(AW, 2) || cyc != 2) begin errors++; $display("FAIL tie_model: got %h want %h cyc=%0d", obs, model(AW, 2), cyc); end
  endtask

  task automatic test_zero_len();
    int rdy = 0;
    start = 1; n_samples = '0;
    @(negedge clk);
    start = 0;
    checks++; if ({done, busy, in_ready} !== 3'b100) begin errors++; $display("FAIL zero_done: got %b want 100", {done, busy, in_ready}); end
    checks++; if (obs !== '0) begin errors++; $display("FAIL zero_stats: got %h want 0", obs); end
    in_valid = 1;
    repeat (4) begin if (in_ready) rdy++; @(negedge clk); end
    in_valid = 0;
    checks++; if (rdy != 0 || sample_cnt !== 0) begin errors++; $display("FAIL zero_ready: ready_cycles=%0d cnt=%0d want 0/0", rdy, sample_cnt); end
  endtask

  task automatic test_back_to_back();
    int acc = 0, badr = 0, cyc;
    beat_t bt;
    bq.delete();
    do_start(4);
    for (int k = 0; k < 10; k++) begin
      bt = rnd_beat();
      in_valid = 1; in_a = bt.a; in_b = bt.b; in_sum = bt.s;
      start = (k == 2); n_samples = (k == 2) ? CW'(7) : CW'(4);
      if (in_ready !== (k < 4)) begin badr++; $display("FAIL b2b_ready: cycle %0d got %b want %b", k, in_ready, k < 4); end
      if (in_ready) acc++;
      if (k < 4) bq.push_back(bt);
      @(negedge clk);
    end
    in_valid = 0; start = 0;
    wait_done(cyc);
    checks++; if (badr != 0 || acc != 4) begin errors++; $display("FAIL b2b_accepts: got %0d bad=%0d want 4", acc, badr); end
    checks++; if (obs !== model(AW, 4) || done !== 1'b1) begin errors++; $display("FAIL b2b_stats: got %h want %h", obs, model(AW, 4)); end
  endtask

  task automatic test_random();
    int n, bad, cyc;
    for (int w = 0; w < 5; w++) begin
      n = $urandom_range(1, 12);
      bq.delete();
      for (int i = 0; i < n; i++) bq.push_back(rnd_beat());
      do_start(n);
      feed(1, bad);
      wait_done(cyc);
      checks++; if (cyc != 2 || bad != 0) begin errors++; $display("FAIL rand_lat w%0d: cyc=%0d bad=%0d", w, cyc, bad); end
      checks++; if (obs !== model(AW, n)) begin errors++; $display("FAIL rand_stats w%0d: got %h want %h", w, obs, model(AW, n)); end
      checks++; if (obs8 !== model(8, n)) begin errors++; $display("FAIL rand_stats8 w%0d: got %h want %h", w, obs8, model(8, n)); end
    end
  endtask

  task automatic test_saturate_reset();
    int bad, cyc;
    bq.delete();
    repeat (3) bq.push_back('{a:16'h0000, b:16'h0000, s:17'h00100});
    do_start(3);
    feed(0, bad);
    wait_done(cyc);
    checks++; if (d8_err_sum !== 8'hFF || d8_acc_sat !== 1'b1) begin errors++; $display("FAIL sat8: sum=%h sat=%b want ff/1", d8_err_sum, d8_acc_sat); end
    checks++; if (obs8 !== model(8, 3) || obs !== model(AW, 3)) begin errors++; $display("FAIL sat_model: got %h / %h", obs8, obs); end
    bq.delete();
    repeat (2) bq.push_back(rnd_beat());
    do_start(5);
    feed(0, bad);
    rst_n = 0;
    @(negedge clk);
    checks++; if (obs !== '0 || obs8 !== '0) begin errors++; $display("FAIL midreset_stats: got %h / %h want 0", obs, obs8); end
    checks++; if ({in_ready, busy, done, d8_in_ready, d8_busy, d8_done} !== 6'b0)
      begin errors++; $display("FAIL midreset_flags: got %b want 0", {in_ready, busy, done, d8_in_ready, d8_busy, d8_done}); end
    rst_n = 1;
    @(negedge clk);
    checks++; if ({in_ready, busy, done} !== 3'b000) begin errors++; $display("FAIL postreset_idle: got %b want 000", {in_ready, busy, done}); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_error_max();
    test_tie();
    test_zero_len();
    test_back_to_back();
    test_random();
    test_saturate_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/approx_err_monitor.md
Name: approx_err_monitor

Overview:
- Streaming error-metric evaluator for approximate WIDTH-bit adders. It sits at the output side of a device-under-test adder in characterisation and emulation harnesses.
- Each accepted beat carries both operands and the approximate sum. The block computes the exact sum and the absolute error, then accumulates over a programmed window of N samples:
  - error count
  - error-distance sum (the MAE numerator)
  - worst-case error and the operands that produced it
- Statistics are held until the next start.

Parameters:
- WIDTH, 16, operand width; the approximate sum is WIDTH+1 bits.
- CNT_W, 32, width of the sample counter, window length and error counter.
- ACC_W, 48, width of the error-distance accumulator.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  pulse; begins a window using n_samples.
- n_samples  in  CNT_W  window length; sampled when start is accepted.
- in_valid  in  1  sample beat valid.
- in_ready  out  1  sample beat ready.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_sum  in  WIDTH+1  approximate sum from the DUT.
- busy  out  1  window in progress.
- done  out  1  window complete; statistics stable.
- sample_cnt  out  CNT_W  beats accepted in this window.
- err_cnt  out  CNT_W  beats with nonzero error.
- err_sum  out  ACC_W  sum of absolute errors, saturating.
- err_max  out  WIDTH+1  largest absolute error.
- max_a  out  WIDTH  in_a of the first beat that reached err_max.
- max_b  out  WIDTH  in_b of the same beat.
- acc_sat  out  1  err_sum has saturated.

Behaviour:
- Reset (rst_n low at a clock edge): FSM to IDLE; every output 0, including in_ready, busy and done; pipeline valid bits cleared. Reset mid-window abandons the window with no partial result retained.
- FSM has four states: IDLE, RUN, DRAIN, DONE.
- IDLE, or DONE, with start=1:
  - Clear all statistics, load the window length from n_samples.
  - If n_samples==0, go to DONE; otherwise go to RUN.
- start is ignored in RUN and DRAIN.
- RUN:
  - in_ready=1 and busy=1.
  - A beat is accepted when in_valid & in_ready.
  - On the accept that makes sample_cnt equal the window length, in_ready drops the next cycle and the FSM moves to DRAIN.
- DRAIN:
  - busy=1, in_ready=0.
  - Waits until both pipeline stages are empty, then moves to DONE.
- DONE: done=1, busy=0, and all statistic outputs are frozen.
- Pipeline stage 1 (registered on accept):
  - exact = in_a + in_b, zero-extended to WIDTH+1 bits.
  - abs_err = |in_sum - exact|, computed in WIDTH+2-bit signed arithmetic, result WIDTH+1 bits.
  - The operands are registered alongside.
- Pipeline stage 2 (the cycle after stage 1):
  - sample_cnt increments.
  - err_cnt increments if abs_err != 0.
  - err_sum += abs_err, saturating at all-ones; acc_sat is sticky once set.
  - If abs_err > err_max (strictly greater), update err_max, max_a and max_b. Ties keep the earlier beat.
- Latency: an accepted beat is reflected in the outputs 2 cycles after acceptance. done rises the cycle after the final beat's stage-2 update.
- Counters: sample_cnt and err_cnt cannot overflow, because the window length is at most 2^CNT_W-1.
- Backpressure: in_ready depends only on FSM state, never on in_valid. A beat presented while in_ready=0 is not consumed.

Decomposition:
- Shared package approx_eval_pkg holds:
  - state enum: IDLE, RUN, DRAIN, DONE
  - default widths
  - a saturating-add function
- One sub-module, approx_err_calc: the combinational exact-sum and absolute-error unit, with ports a, b, approx_sum, abs_err. It is reusable by other characterisation blocks.

Test Plan:
1. n_samples=1; beat a=0x0001, b=0x0001, sum=0x00002 -> done after 3 cycles; sample_cnt=1, err_cnt=0, err_sum=0, err_max=0.
2. n_samples=2; beats (0x07FF, 0x0001, sum=0x00000) then (0xFFFF, 0xFFFF, sum=0x1FFFE) -> err_cnt=1, err_sum=0x800, err_max=0x800, max_a=0x07FF, max_b=0x0001.
3. Tie on max: two beats, each with abs error 5, second with different operands -> max_a and max_b hold the first beat's operands.
4. n_samples=0 with start -> done the next cycle; in_ready never high; all statistics 0.
5. in_valid held high for 10 cycles with n_samples=4 -> exactly 4 accepts, in_ready low from the 5th cycle; start during RUN has no effect.
6. ACC_W=8 override; beats each with error 0x100 -> err_sum=0xFF, acc_sat=1. Then rst_n=0 mid-window -> all outputs 0 the next cycle.
